// File: rtl/multi_rate_tick_gen.sv
// ---------------------------------------------------------------------------
// multi_rate_tick_gen
//
// Generates N_CH independent single-cycle clock-enable ticks from the system
// clock. Downstream logic gates on tick[c] instead of being clocked from a
// divided net, so the whole design stays in the single `clock` domain.
//
// Each channel owns a counter, an active divisor, a shadow divisor and a
// pending flag. A newly loaded divisor waits in the shadow register until the
// current period wraps, so no period is ever cut short or stretched.
// A divisor of 0 behaves as 1.
//
// Parameters:
//   N_CH        number of tick channels (1..8)
//   CH_W        width of the channel select (2**CH_W >= N_CH)
//   DIV_W       divisor / counter width
//   DEFAULT_DIV divisor every channel takes on reset
//
// Ports:
//   clock     system clock
//   reset     synchronous, active-high initialisation
//   run       global count enable (0: counters hold, no ticks)
//   ch_en     per-channel enable (0: counter cleared, pending divisor applied)
//   sync      one-cycle pulse that zeroes all counters
//   load      one-cycle divisor write strobe
//   load_ch   channel addressed by load (values >= N_CH are ignored)
//   load_div  new divisor value
//   tick      registered one-cycle pulse per channel period
//   square    50% duty toggle per channel, period 2*D
//             (only when TICKGEN_SQUARE_EN is defined)
//
// Optional feature macro: TICKGEN_SQUARE_EN
// ---------------------------------------------------------------------------
module multi_rate_tick_gen #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 10_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_div,
  output logic [N_CH-1:0]   tick
`ifdef TICKGEN_SQUARE_EN
  ,
  output logic [N_CH-1:0]   square
`endif
);

  logic [N_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][DIV_W-1:0] div_q, div_d;
  logic [N_CH-1:0][DIV_W-1:0] shd_q, shd_d;
  logic [N_CH-1:0]            pend_q, pend_d;
  logic [N_CH-1:0]            tick_q, tick_d;
`ifdef TICKGEN_SQUARE_EN
  logic [N_CH-1:0]            sq_q, sq_d;
`endif

  logic [N_CH-1:0][DIV_W-1:0] last_cnt;
  logic [N_CH-1:0]            at_last;

  // Terminal count per channel is D-1 with D = max(div, 1), so a zero
  // divisor wraps every cycle exactly like a divisor of one.
  always_comb begin
    last_cnt = '0;
    at_last  = '0;
    for (int c = 0; c < N_CH; c++) begin
      last_cnt[c] = (div_q[c] == '0) ? '0 : div_q[c] - DIV_W'(1);
      at_last[c]  = (cnt_q[c] == last_cnt[c]);
    end
  end

  // Per-channel next state. Priority is sync, then channel disable, then
  // the global run hold, then normal counting. The shadow write from a load
  // is evaluated after the channel update, so a load that lands on a wrap
  // or disable edge stays pending for the next period instead of being lost.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    tick_d = '0;
`ifdef TICKGEN_SQUARE_EN
    sq_d   = sq_q;
`endif
    for (int c = 0; c < N_CH; c++) begin
      if (sync) begin
        cnt_d[c] = '0;
      end else if (!ch_en[c]) begin
        cnt_d[c] = '0;
        if (pend_q[c]) begin
          div_d[c]  = shd_q[c];
          pend_d[c] = 1'b0;
        end
      end else if (!run) begin
        cnt_d[c] = cnt_q[c];
      end else if (at_last[c]) begin
        cnt_d[c]  = '0;
        tick_d[c] = 1'b1;
`ifdef TICKGEN_SQUARE_EN
        sq_d[c]   = ~sq_q[c];
`endif
        if (pend_q[c]) begin
          div_d[c]  = shd_q[c];
          pend_d[c] = 1'b0;
        end
      end else begin
        cnt_d[c] = cnt_q[c] + DIV_W'(1);
      end

      if (load && (load_ch == CH_W'(c))) begin
        shd_d[c]  = load_div;
        pend_d[c] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; a load coinciding with reset is
  // discarded because reset takes the whole register set.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= {N_CH{DIV_W'(DEFAULT_DIV)}};
      shd_q  <= {N_CH{DIV_W'(DEFAULT_DIV)}};
      pend_q <= '0;
      tick_q <= '0;
`ifdef TICKGEN_SQUARE_EN
      sq_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
`ifdef TICKGEN_SQUARE_EN
      sq_q   <= sq_d;
`endif
    end
  end

  assign tick = tick_q;
`ifdef TICKGEN_SQUARE_EN
  assign square = sq_q;
`endif

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_rate_tick_gen
//
// Directed bench for multi_rate_tick_gen with N_CH=2 and DEFAULT_DIV=5.
// Each scenario task numbers the clock edges after reset release as e=1,2,...
// applies its stimulus before edge e, samples 1 time unit after the edge and
// compares against hand-derived tick positions.
// Square-wave checks are built only when TICKGEN_SQUARE_EN is defined.
// ---------------------------------------------------------------------------
module tb_multi_rate_tick_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [1:0] ch_en;
  logic       sync;
  logic       load;
  logic [1:0] load_ch;
  logic [7:0] load_div;
  logic [1:0] tick;
`ifdef TICKGEN_SQUARE_EN
  logic [1:0] square;
`endif

  int checks = 0;
  int errors = 0;

  // 100 MHz bench clock; only cycle counts matter here
  always #5 clock = ~clock;

  multi_rate_tick_gen #(
    .N_CH        (2),
    .CH_W        (2),
    .DIV_W       (8),
    .DEFAULT_DIV (5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .ch_en    (ch_en),
    .sync     (sync),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .tick     (tick)
`ifdef TICKGEN_SQUARE_EN
    ,
    .square   (square)
`endif
  );

  // Advance one active edge and settle just past it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Idle input values: counting on both channels, no strobes
  task automatic idle_inputs();
    run      = 1'b1;
    ch_en    = 2'b11;
    sync     = 1'b0;
    load     = 1'b0;
    load_ch  = 2'd0;
    load_div = 8'd0;
  endtask

  // One reset cycle, then release
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_load(input logic [1:0] ch, input logic [7:0] v);
    load     = 1'b1;
    load_ch  = ch;
    load_div = v;
  endtask

  // Reset clears outputs; defaults D=5 tick on edges 5, 10, 15
  task automatic test_reset();
    logic [1:0] exp;
    idle_inputs();
    reset = 1'b1;
    step();
    if (tick !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_tick tick=%b expected=%b", tick, 2'b00);
    end
    checks++;
`ifdef TICKGEN_SQUARE_EN
    if (square !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_square square=%b expected=%b", square, 2'b00);
    end
    checks++;
`endif
    step();
    if (tick !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_hold tick=%b expected=%b", tick, 2'b00);
    end
    checks++;
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp = (e % 5 == 0) ? 2'b11 : 2'b00;
      if (tick !== exp) begin
        errors++;
        $display("[TB] FAIL defaults e=%0d tick=%b expected=%b", e, tick, exp);
      end
      checks++;
    end
  endtask

  // Divisor 0 and 1 both tick every cycle; then 3 ticks every third cycle
  task automatic test_divisor_edges();
    logic exp;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      load = 1'b0;
      case (e)
        1:  set_load(2'd0, 8'd0);
        9:  set_load(2'd0, 8'd1);
        13: set_load(2'd0, 8'd3);
        default: ;
      endcase
      step();
      exp = (e >= 5 && e <= 14) || e == 17 || e == 20;
      if (tick[0] !== exp) begin
        errors++;
        $display("[TB] FAIL div_edges e=%0d tick0=%b expected=%b", e, tick[0], exp);
      end
      checks++;
    end
    load = 1'b0;
  endtask

  // D=8 then reload 2 at cnt=3: full 8-cycle period, then every 2
  task automatic test_mid_reload();
    logic [1:0] exp;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      load = 1'b0;
      case (e)
        1: set_load(2'd0, 8'd8);
        9: set_load(2'd0, 8'd2);
        default: ;
      endcase
      step();
      exp[0] = e == 5 || e == 13 || e == 15 || e == 17 || e == 19;
      exp[1] = (e % 5 == 0);
      if (tick !== exp) begin
        errors++;
        $display("[TB] FAIL mid_reload e=%0d tick=%b expected=%b", e, tick, exp);
      end
      checks++;
    end
    load = 1'b0;
  endtask

  // Last load before a wrap wins
  task automatic test_back_to_back();
    logic [1:0] exp;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      load = 1'b0;
      case (e)
        1: set_load(2'd0, 8'd7);
        2: set_load(2'd0, 8'd2);
        default: ;
      endcase
      step();
      exp[0] = e == 5 || e == 7 || e == 9 || e == 11;
      exp[1] = (e % 5 == 0);
      if (tick !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back e=%0d tick=%b expected=%b", e, tick, exp);
      end
      checks++;
    end
    load = 1'b0;
  endtask

  // Both channels at D=4 but out of phase; sync on ch0's wrap edge
  // suppresses that tick and aligns both channels
  task automatic test_sync();
    logic [1:0] exp;
    do_reset();
    for (int e = 1; e <= 21; e++) begin
      load  = 1'b0;
      sync  = (e == 13);
      ch_en = (e == 6) ? 2'b01 : 2'b11;
      case (e)
        1: set_load(2'd0, 8'd4);
        2: set_load(2'd1, 8'd4);
        default: ;
      endcase
      step();
      exp[0] = e == 5 || e == 9 || e == 17 || e == 21;
      exp[1] = e == 5 || e == 10 || e == 17 || e == 21;
      if (tick !== exp) begin
        errors++;
        $display("[TB] FAIL sync e=%0d tick=%b expected=%b", e, tick, exp);
      end
      checks++;
    end
    idle_inputs();
  endtask

  // run=0 for 10 edges freezes the count; disabling ch1 applies a pending
  // divisor of 6 immediately and counting restarts from 0 on re-enable
  task automatic test_hold_disable();
    logic [1:0] exp;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      load  = 1'b0;
      run   = !(e >= 3 && e <= 12);
      ch_en = (e == 17) ? 2'b01 : 2'b11;
      if (e == 16) set_load(2'd1, 8'd6);
      step();
      exp[0] = e == 15 || e == 20 || e == 25 || e == 30;
      exp[1] = e == 15 || e == 23 || e == 29;
      if (tick !== exp) begin
        errors++;
        $display("[TB] FAIL hold_disable e=%0d tick=%b expected=%b", e, tick, exp);
      end
      checks++;
    end
    idle_inputs();
  endtask

  // Load coinciding with reset and load to channel 3 are both ignored
  task automatic test_ignored_loads();
    logic [1:0] exp;
    idle_inputs();
    reset = 1'b1;
    set_load(2'd0, 8'd1);
    step();
    reset = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      load = 1'b0;
      if (e == 1) set_load(2'd3, 8'd1);
      step();
      exp = (e % 5 == 0) ? 2'b11 : 2'b00;
      if (tick !== exp) begin
        errors++;
        $display("[TB] FAIL ignored_load e=%0d tick=%b expected=%b", e, tick, exp);
      end
      checks++;
    end
    load = 1'b0;
  endtask

`ifdef TICKGEN_SQUARE_EN
  // D=3: square[0] toggles on each wrap, period 6 with 50% duty
  task automatic test_square();
    logic exp_sq;
    logic exp_tk;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      load = 1'b0;
      if (e == 1) set_load(2'd0, 8'd3);
      step();
      exp_sq = (e >= 5 && e <= 7) || (e >= 11 && e <= 13);
      exp_tk = e == 5 || e == 8 || e == 11 || e == 14;
      if (square[0] !== exp_sq) begin
        errors++;
        $display("[TB] FAIL square e=%0d square0=%b expected=%b", e, square[0], exp_sq);
      end
      checks++;
      if (tick[0] !== exp_tk) begin
        errors++;
        $display("[TB] FAIL square_tick e=%0d tick0=%b expected=%b", e, tick[0], exp_tk);
      end
      checks++;
    end
    load = 1'b0;
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    $display("[TB] starting multi_rate_tick_gen bench");
    test_reset();
    test_divisor_edges();
    test_mid_reload();
    test_back_to_back();
    test_sync();
    test_hold_disable();
    test_ignored_loads();
`ifdef TICKGEN_SQUARE_EN
    test_square();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_rate_tick_gen.md
# multi_rate_tick_gen

Parametrised, multi-channel successor to the fixed 50 MHz → 5 Hz divider chain. It generates N_CH independent single-cycle clock-enable ticks from the system clock. Each channel has a runtime-loadable divisor, a per-channel enable, and a global resync. Everything runs in the single `clock` domain with no derived clocks, so downstream logic (display multiplexing, debounce, blink timers) gates on `tick[c]` instead of clocking from divided nets.

## Interface
Parameters:
- `N_CH`, 4: number of tick channels (1..8)
- `CH_W`, 2: width of channel select; must satisfy 2^CH_W ≥ N_CH
- `DIV_W`, 24: divisor/counter width per channel
- `DEFAULT_DIV`, 10_000_000: reset divisor for every channel (50 MHz → 5 Hz)

Ports:
- `clock` in 1: system clock (50 MHz nominal)
- `reset` in 1: synchronous, active-high; one clock with `reset`=1 fully initialises the block
- `run` in 1: global count enable; when 0, all counters hold and no ticks are issued
- `ch_en` in N_CH: per-channel enable
- `sync` in 1: one-cycle pulse that zeroes all channel counters
- `load` in 1: one-cycle write strobe for a divisor
- `load_ch` in CH_W: channel addressed by `load`
- `load_div` in DIV_W: new divisor value
- `tick` out N_CH: registered one-cycle pulse per channel period
- `square` out N_CH: 50 %-duty toggle per channel (present only with `TICKGEN_SQUARE_EN`)

## Operation
- Per channel c:
  - Registers: `cnt[c]`, active divisor `div[c]`, shadow divisor `shd[c]`, and pending flag `pend[c]`.
  - Effective divisor D = max(`div[c]`, 1), so a divisor of 0 behaves as 1.
- Priority at each rising edge, per channel, highest first:
  1. `reset`: `cnt`←0, `div`←`shd`←DEFAULT_DIV, `pend`←0, `tick`←0, `square`←0.
  2. `sync`: `cnt`←0, `tick`←0. This applies even when a wrap was due that cycle, so no tick is issued.
  3. `ch_en[c]`=0: `cnt`←0, `tick`←0. A pending divisor applies immediately (`div`←`shd`, `pend`←0).
  4. `run`=0: `cnt` holds, `tick`←0.
  5. Otherwise, count:
     - If `cnt`==D−1: `cnt`←0, `tick`←1, toggle `square`. If `pend` is set, `div`←`shd` and `pend`←0.
     - Else: `cnt`←`cnt`+1, `tick`←0.
- Divisor load: `load`=1 with `load_ch`<N_CH writes `shd[load_ch]`←`load_div` and sets `pend`.
  - The new period starts only after the current period completes, so there are no runt or stretched periods.
  - `load_ch`≥N_CH is ignored.
  - Load on the same edge as `reset`: ignored.
  - Load on the same edge as `sync`: the shadow is written, and the `sync` is honoured.
- Back-to-back loads to one channel before a wrap: last value wins.
- `cnt` never exceeds D−1. If a channel is disabled and re-enabled, counting restarts from 0.

## Timing
- After `reset` deasserts with `run`=`ch_en`=1 and divisor D, `tick[c]` is first high in the cycle after the D-th active edge. After that it is high for exactly one cycle every D cycles.
- D=1: `tick` stays high continuously while counting.
- Latency from an enable/run edge to a counter change is one clock. There is no combinational path from any input to any output.
- A divisor loaded mid-period takes effect at the next wrap. The first period using the new divisor begins on the cycle after that wrap's tick.
- `sync` aligns all channels. For equal divisors, the ticks of every channel coincide from then on.

## Configuration
- `TICKGEN_SQUARE_EN` defined: the `square` port exists and toggles on every tick, giving period 2·D and 50 % duty. Reset value is 0, and `sync` does not alter `square`.
- `TICKGEN_SQUARE_EN` undefined: the port and its flops are absent, and `tick` behaviour is identical.

## Test plan
- Defaults: override DEFAULT_DIV=5, N_CH=2, reset for 1 cycle, `run`=`ch_en`=2'b11 → `tick` pulses at cycles 5, 10, 15 after reset deasserts; all outputs are 0 during reset.
- Divisor edge cases: load 0, then 1, then 3 into ch0 → after the following wraps, ch0 ticks every cycle (for both 0 and 1), then every 3 cycles.
- Mid-period reload: with D=8, at `cnt`=3 load 2 → ch0 completes its 8-cycle period, then ticks every 2 cycles; no tick gap of less than 2 or more than 8.
- Sync collision: with D=4, assert `sync` on the edge where `cnt`=3 → no tick that cycle, and the next tick arrives 4 cycles later; ch0 and ch1 (both D=4) are then simultaneous.
- Hold and disable: `run`=0 for 10 cycles mid-period → `cnt` frozen and no ticks, then resumes with the remaining count. `ch_en[1]`=0 with a pending load of 6 → divisor applies at once; ch1 ticks 6 cycles after re-enable.
- With `TICKGEN_SQUARE_EN` and D=3: `square[0]` has period 6 and 50 % duty; `load_ch`=3 with N_CH=2 changes nothing.
